led_bus_arbiter: RTL and testbench

- Owns the 8-bit LEDG bus and arbitrates it between the NIOS II GPIO export and a hardware heartbeat generator.
- The CPU drives the LEDs while it shows signs of life, meaning its GPIO pattern changes within a timeout window.
- Before the first CPU write, after a CPU stall, or when the force switch is set, hardware drives a heartbeat instead.
- Sits between the Platform Designer system's gpio_external_connection_export and the board LEDG pins.

---
 rtl/led_arb_pkg.sv | 27 ++
 rtl/led_heartbeat_gen.sv | 53 +++++
 rtl/led_bus_arbiter.sv | 131 +++++++++++++
 tb/tb_led_bus_arbiter.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/led_arb_pkg.sv
// Shared encodings for the LED bus arbiter: FSM states, mode codes, default width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package led_arb_pkg;

    localparam int DEF_LED_W = 8;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_CPU   = 2'd1,
        ST_STALE = 2'd2
    } state_t;

    localparam logic [1:0] MODE_BOOT   = 2'b00;
    localparam logic [1:0] MODE_CPU    = 2'b01;
    localparam logic [1:0] MODE_STALE  = 2'b10;
    localparam logic [1:0] MODE_FORCED = 2'b11;

    function automatic logic [1:0] state_mode(input state_t s);
        case (s)
            ST_CPU:   state_mode = MODE_CPU;
            ST_STALE: state_mode = MODE_STALE;
            default:  state_mode = MODE_BOOT;
        endcase
    endfunction

endpackage

// File: rtl/led_heartbeat_gen.sv
// Free-running heartbeat: prescaler, hb level toggle, optional chase rotator (LED_BUS_ARBITER_CHASE_EN).
// Latency: tick is combinational on terminal count; hb and chase update on that edge.
// Backpressure: none, runs continuously from reset regardless of arbiter state.
module led_heartbeat_gen
    import led_arb_pkg::*;
#(
`ifdef LED_BUS_ARBITER_CHASE_EN
    parameter int LED_W       = DEF_LED_W,
`endif
    parameter int HB_HALF_CYC = 25_000_000
) (
    input  logic             core_clk,
    input  logic             arst_n,
`ifdef LED_BUS_ARBITER_CHASE_EN
    input  logic             chase_ld,
    output logic [LED_W-1:0] chase,
`endif
    output logic             hb,
    output logic             tick
);
    localparam int PW = (HB_HALF_CYC > 1) ? $clog2(HB_HALF_CYC) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(HB_HALF_CYC - 1);

    logic [PW-1:0] pre;

    assign tick = (pre == PRE_MAX);

    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            pre <= '0;
            hb  <= 1'b0;
        end else if (tick) begin
            pre <= '0;
            hb  <= ~hb;
        end else begin
            pre <= pre + PW'(1);
        end
    end

`ifdef LED_BUS_ARBITER_CHASE_EN
    // Load wins over rotate so STALE entry always restarts the chase at bit 0.
    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            chase <= '0;
        end else if (chase_ld) begin
            chase <= LED_W'(1);
        end else if (tick) begin
            chase <= {chase[LED_W-2:0], chase[LED_W-1]};
        end
    end
`endif

endmodule

// File: rtl/led_bus_arbiter.sv
// Arbitrates LEDG between the NIOS GPIO export and a heartbeat; chase pattern under LED_BUS_ARBITER_CHASE_EN.
// Latency: 1 cycle gpio_led -> LEDG in CPU mode; force_hw takes 2 sync + 1 output cycles.
// Backpressure: none, LEDG/mode/cpu_alive are re-registered every cycle.
module led_bus_arbiter
    import led_arb_pkg::*;
#(
    parameter int LED_W       = DEF_LED_W,
    parameter int HB_HALF_CYC = 25_000_000,
    parameter int TIMEOUT_CYC = 100_000_000,
    parameter int HB_BIT      = 3
) (
    input  logic             CLOCK_50,
    input  logic             RESET,
    input  logic [LED_W-1:0] gpio_led,
    input  logic             force_hw,
    output logic [LED_W-1:0] LEDG,
    output logic [1:0]       mode,
    output logic             cpu_alive
);
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYC - 1);

    logic [LED_W-1:0] gpio_q;
    logic             chg;
    logic             fh_m;
    logic             fh_s;
    state_t           state;
    state_t           state_nxt;
    logic [TW-1:0]    tmo;
    logic             hb;
    logic             tick;
    logic             hb_nxt;
    logic [LED_W-1:0] hb_pat;
    logic [LED_W-1:0] stale_pat;
    logic [LED_W-1:0] led_nxt;
    logic [1:0]       mode_nxt;

`ifdef LED_BUS_ARBITER_CHASE_EN
    logic             chase_ld;
    logic [LED_W-1:0] chase;

    assign chase_ld = (state_nxt == ST_STALE) && (state != ST_STALE);

    led_heartbeat_gen #(
        .LED_W       (LED_W),
        .HB_HALF_CYC (HB_HALF_CYC)
    ) u_hb (
        .core_clk (CLOCK_50),
        .arst_n   (RESET),
        .chase_ld (chase_ld),
        .chase    (chase),
        .hb       (hb),
        .tick     (tick)
    );
`else
    led_heartbeat_gen #(
        .HB_HALF_CYC (HB_HALF_CYC)
    ) u_hb (
        .core_clk (CLOCK_50),
        .arst_n   (RESET),
        .hb       (hb),
        .tick     (tick)
    );
`endif

    // A zero write straight after reset matches the cleared gpio_q, so it is not a change.
    assign chg    = (gpio_led != gpio_q);
    // Output is built from next-state values, so the LED level tracks the toggle edge itself.
    assign hb_nxt = hb ^ tick;

    always_comb begin
        hb_pat         = '0;
        hb_pat[HB_BIT] = hb_nxt;
`ifdef LED_BUS_ARBITER_CHASE_EN
        stale_pat      = chase_ld ? LED_W'(1) : chase;
`else
        stale_pat      = hb_pat;
`endif
        stale_pat[LED_W-1] = 1'b1;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_BOOT:  if (chg) state_nxt = ST_CPU;
            ST_CPU:   if (!chg && (tmo == TMO_MAX)) state_nxt = ST_STALE;
            ST_STALE: if (chg) state_nxt = ST_CPU;
            default:  state_nxt = ST_BOOT;
        endcase
    end

    always_comb begin
        led_nxt  = hb_pat;
        mode_nxt = MODE_FORCED;
        if (!fh_s) begin
            mode_nxt = state_mode(state_nxt);
            case (state_nxt)
                ST_CPU:   led_nxt = gpio_led;
                ST_STALE: led_nxt = stale_pat;
                default:  led_nxt = hb_pat;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET) begin
        if (!RESET) begin
            gpio_q    <= '0;
            fh_m      <= 1'b0;
            fh_s      <= 1'b0;
            state     <= ST_BOOT;
            tmo       <= '0;
            LEDG      <= '0;
            mode      <= MODE_BOOT;
            cpu_alive <= 1'b0;
        end else begin
            gpio_q <= gpio_led;
            fh_m   <= force_hw;
            fh_s   <= fh_m;
            state  <= state_nxt;
            if (chg) begin
                tmo <= '0;
            end else if ((state == ST_CPU) && (tmo != TMO_MAX)) begin
                tmo <= tmo + TW'(1);
            end
            LEDG      <= led_nxt;
            mode      <= mode_nxt;
            cpu_alive <= (state_nxt == ST_CPU);
        end
    end

endmodule

// File: tb/tb_led_bus_arbiter.sv
// Bench for led_bus_arbiter: directed scenarios plus random GPIO/force traffic against a cycle model.
module tb_led_bus_arbiter;
    localparam int HB  = 4;
    localparam int TMO = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] gpio = 8'h00;
    logic       force_hw = 1'b0;
    logic [7:0] ledg;
    logic [1:0] mode;
    logic       alive;

    int checks = 0;
    int errors = 0;

    // Reference model: source, quiet-edge count, edges since reset, force history.
    int         n_edges;
    logic [7:0] m_last;
    int         m_src;
    int         m_quiet;
    logic       fp1;
    logic       fp2;
    logic [7:0] e_led;
    logic [1:0] e_mode;
    logic       e_alive;

    led_bus_arbiter #(
        .LED_W       (8),
        .HB_HALF_CYC (HB),
        .TIMEOUT_CYC (TMO),
        .HB_BIT      (3)
    ) dut (
        .CLOCK_50  (clk),
        .RESET     (rst_n),
        .gpio_led  (gpio),
        .force_hw  (force_hw),
        .LEDG      (ledg),
        .mode      (mode),
        .cpu_alive (alive)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        n_edges = 0;
        m_last  = 8'h00;
        m_src   = 0;
        m_quiet = 0;
        fp1     = 1'b0;
        fp2     = 1'b0;
        e_led   = 8'h00;
        e_mode  = 2'b00;
        e_alive = 1'b0;
    endtask

    task automatic model_step();
        logic       chg;
        logic       fs;
        logic [7:0] hbpat;
        chg    = (gpio != m_last);
        m_last = gpio;
        n_edges++;
        hbpat  = (((n_edges / HB) % 2) == 1) ? 8'h08 : 8'h00;
        fs     = fp2;
        fp2    = fp1;
        fp1    = force_hw;
        if (chg) begin
            m_src   = 1;
            m_quiet = 0;
        end else if (m_src == 1) begin
            m_quiet++;
            if (m_quiet == TMO) m_src = 2;
        end
        e_alive = (m_src == 1);
        if (fs) begin
            e_led  = hbpat;
            e_mode = 2'b11;
        end else begin
            e_mode = 2'(m_src);
            case (m_src)
                0:       e_led = hbpat;
                1:       e_led = gpio;
                default: e_led = hbpat | 8'h80;
            endcase
        end
    endtask

    task automatic cyc(input logic [7:0] g, input logic f);
        gpio     = g;
        force_hw = f;
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("ledg", 32'(ledg), 32'(e_led));
        check("mode", 32'(mode), 32'(e_mode));
        check("cpu_alive", 32'(alive), 32'(e_alive));
    endtask

    initial begin
        logic [7:0] g;
        logic       f;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ledg", 32'(ledg), 32'h00);
        check("rst_mode", 32'(mode), 32'h0);
        check("rst_alive", 32'(alive), 32'h0);
        rst_n = 1'b1;
        model_reset();

        // Idle boot heartbeat, then first CPU write and timeout to STALE.
        repeat (20) cyc(8'h00, 1'b0);
        cyc(8'hA5, 1'b0);
        check("a5_latency", 32'(ledg), 32'hA5);
        repeat (15) cyc(8'hA5, 1'b0);
        check("still_cpu_15", 32'(mode), 32'h1);
        cyc(8'hA5, 1'b0);
        check("stale_at_16", 32'(mode), 32'h2);
        repeat (12) cyc(8'hA5, 1'b0);
        cyc(8'h3C, 1'b0);
        check("recover_3c", 32'(ledg), 32'h3C);

        // Change lands on the edge where the counter sits at its maximum.
        cyc(8'h11, 1'b0);
        repeat (15) cyc(8'h11, 1'b0);
        cyc(8'h22, 1'b0);
        check("chg_beats_tmo", 32'(mode), 32'h1);
        repeat (15) cyc(8'h22, 1'b0);
        check("no_early_tmo", 32'(mode), 32'h1);
        cyc(8'h22, 1'b0);
        check("tmo_after_chg", 32'(mode), 32'h2);

        // Force override while the CPU is alive.
        cyc(8'h77, 1'b0);
        repeat (2) cyc(8'h77, 1'b0);
        repeat (2) cyc(8'h77, 1'b1);
        check("force_not_yet", 32'(mode), 32'h1);
        cyc(8'h77, 1'b1);
        check("force_mode", 32'(mode), 32'h3);
        check("force_alive", 32'(alive), 32'h1);
        repeat (3) cyc(8'h77, 1'b1);
        repeat (3) cyc(8'h77, 1'b0);
        check("force_release", 32'(ledg), 32'h77);

        // Asynchronous reset while STALE.
        cyc(8'h55, 1'b0);
        repeat (20) cyc(8'h55, 1'b0);
        check("pre_rst_stale", 32'(mode), 32'h2);
        #2 rst_n = 1'b0;
        #1;
        check("arst_ledg", 32'(ledg), 32'h00);
        check("arst_mode", 32'(mode), 32'h0);
        check("arst_alive", 32'(alive), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // Random traffic: sparse GPIO writes so timeouts occur, occasional force flips.
        g = 8'h55;
        f = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 19) == 0) g = 8'($urandom);
            if ($urandom_range(0, 49) == 0) f = ~f;
            cyc(g, f);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
